div_unit: RTL and testbench

- Multi-cycle iterative radix-2 restoring divider for DIV/DIVU.
- Launched from the EXE stage; delivers {remainder, quotient} with a one-cycle valid pulse.
- This is the producer side of the HI/LO write interface: result[63:32] goes to HI (remainder) and result[31:0] goes to LO (quotient).
- HI/LO captures result on the edge where result_ok is high.

---
 rtl/div_unit_pkg.sv | 26 ++
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 113 +++++++++++
 tb/tb_div_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: DIV/DIVU state encodings, latency, HI/LO result field positions
// and the EXE-stage opcodes that launch the divider.
package div_unit_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int HI_MSB = 63;
  localparam int HI_LSB = 32;
  localparam int LO_MSB = 31;
  localparam int LO_LSB = 0;

  localparam logic [5:0] EXE_DIV_OP  = 6'h1A;
  localparam logic [5:0] EXE_DIVU_OP = 6'h1B;

  function automatic logic div_op_signed(input logic [5:0] op);
    return op == EXE_DIV_OP;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring iteration on {rem,quo}.
// No state; result settles within the same cycle.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_rq,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic [2*WIDTH-1:0] o_rq
);

  logic [WIDTH:0]   w_rem_sh;
  logic             w_fits;
  logic [WIDTH-1:0] w_diff;

  // The shifted remainder needs one extra bit; the difference itself always fits WIDTH bits.
  assign w_rem_sh = i_rq[2*WIDTH-1:WIDTH-1];
  assign w_fits   = (w_rem_sh >= {1'b0, i_divisor});
  assign w_diff   = w_rem_sh[WIDTH-1:0] - i_divisor;

  assign o_rq = w_fits ? {w_diff,               i_rq[WIDTH-2:0], 1'b1}
                       : {w_rem_sh[WIDTH-1:0],  i_rq[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative DIV/DIVU, WIDTH+2 cycles start-to-result_ok; no queueing, cancel aborts.
// Macro DIV_FASTPATH_EN: zero dividend/divisor skips CALC (result_ok 2 cycles after start).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               cancel,
  output logic               busy,
  output logic [2*WIDTH-1:0] result,
  output logic               result_ok
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t         r_state, w_state_nxt;
  logic [2*WIDTH-1:0] r_rq, w_rq_step;
  logic [WIDTH-1:0]   r_divisor, r_opa_raw;
  logic               r_quo_neg, r_rem_neg, r_div0;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic               r_result_ok;

  logic               w_launch, w_finish;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo_fix, w_rem_fix;

  assign w_abs_a = (is_signed && opa[WIDTH-1]) ? -opa : opa;
  assign w_abs_b = (is_signed && opb[WIDTH-1]) ? -opb : opb;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rq      (r_rq),
    .i_divisor (r_divisor),
    .o_rq      (w_rq_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        // A start coinciding with the result_ok cycle is dropped; it must be re-issued.
        if (start && !cancel && !r_result_ok) begin
          w_launch = 1'b1;
`ifdef DIV_FASTPATH_EN
          w_state_nxt = (opa == '0 || opb == '0) ? DONE : CALC;
`else
          w_state_nxt = CALC;
`endif
        end
      end
      CALC: begin
        if (cancel)                          w_state_nxt = IDLE;
        else if (r_cnt == CW'(WIDTH - 1))    w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_finish    = !cancel;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_quo_fix = r_quo_neg ? -r_rq[WIDTH-1:0]       : r_rq[WIDTH-1:0];
  assign w_rem_fix = r_rem_neg ? -r_rq[2*WIDTH-1:WIDTH] : r_rq[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rq        <= '0;
      r_divisor   <= '0;
      r_opa_raw   <= '0;
      r_quo_neg   <= 1'b0;
      r_rem_neg   <= 1'b0;
      r_div0      <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_ok <= 1'b0;
    end else begin
      r_result_ok <= w_finish;
      if (w_launch) begin
        r_rq      <= {{WIDTH{1'b0}}, w_abs_a};
        r_divisor <= w_abs_b;
        r_opa_raw <= opa;
        r_quo_neg <= is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        r_rem_neg <= is_signed & opa[WIDTH-1];
        r_div0    <= (opb == '0);
        r_cnt     <= '0;
      end else if (r_state == CALC) begin
        r_rq  <= w_rq_step;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_finish) begin
        r_result <= r_div0 ? {r_opa_raw, {WIDTH{1'b1}}} : {w_rem_fix, w_quo_fix};
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign result    = r_result;
  assign result_ok = r_result_ok;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized DIV/DIVU checks against an arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        cancel;
  logic        busy;
  logic [63:0] result;
  logic        result_ok;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] last_res = '0;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .opa       (opa),
    .opb       (opb),
    .cancel    (cancel),
    .busy      (busy),
    .result    (result),
    .result_ok (result_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: truncating division with remainder following the dividend, div-by-zero defined.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FASTPATH_EN
    return (a == 32'd0 || b == 32'd0) ? 2 : DIV_LATENCY;
`else
    if (a == 32'd0 && b == 32'd0) return DIV_LATENCY;
    return DIV_LATENCY;
`endif
  endfunction

  task automatic launch(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    is_signed = div_op_signed(op);
    opa       = a;
    opb       = b;
    tick();
    start = 1'b0;
    opa   = $urandom;
    opb   = $urandom;
  endtask

  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string tag);
    int lat;
    lat = 0;
    launch(op, a, b);
    check({tag, ".busy_c1"}, busy, 1'b1);
    for (int c = 1; c <= 60; c++) begin
      if (result_ok) begin
        lat = c;
        break;
      end
      tick();
    end
    check({tag, ".latency"}, lat, ref_lat(a, b));
    check({tag, ".hi"}, result[HI_MSB:HI_LSB], exp[HI_MSB:HI_LSB]);
    check({tag, ".lo"}, result[LO_MSB:LO_LSB], exp[LO_MSB:LO_LSB]);
    check({tag, ".busy_at_ok"}, busy, 1'b0);
    tick();
    check({tag, ".ok_pulse"}, result_ok, 1'b0);
    check({tag, ".hold"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    int          cyc, n_ok, first;
    logic        hold_bad, sgn;
    logic [31:0] a, b;
    logic [63:0] prev;

    rst = 1'b0; start = 1'b0; is_signed = 1'b0; cancel = 1'b0; opa = '0; opb = '0;
    tick();
    tick();
    check("rst.busy", busy, 1'b0);
    check("rst.result_ok", result_ok, 1'b0);
    check("rst.result", result, 64'd0);
    rst = 1'b1;
    tick();

    do_op(EXE_DIVU_OP, 32'd100, 32'd7, 64'h00000002_0000000E, "divu_100_7");
    do_op(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2");
    do_op(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, "div_7_m2");
    do_op(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, "div_ovf");
    do_op(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, "div_by0");
    do_op(EXE_DIVU_OP, 32'd0, 32'd9, 64'h0, "divu_zero");
    do_op(EXE_DIVU_OP, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, "divu_by0");

    // Cancel mid-CALC at cycle 10, then relaunch at cycle 12.
    prev = last_res;
    launch(EXE_DIVU_OP, 32'd100, 32'd7);
    cyc = 1;
    while (cyc < 10) begin tick(); cyc++; end
    cancel = 1'b1;
    tick(); cyc++;
    cancel = 1'b0;
    check("cancel.busy_c11", busy, 1'b0);
    check("cancel.result_kept", result, prev);
    tick(); cyc++;
    start = 1'b1; is_signed = 1'b0; opa = 32'd100; opb = 32'd7;
    n_ok = 0; first = 0; hold_bad = 1'b0;
    while (cyc <= 60) begin
      if (result_ok) begin
        n_ok++;
        if (first == 0) first = cyc;
      end
      if (first == 0 && result !== prev) hold_bad = 1'b1;
      tick(); cyc++;
      start = 1'b0;
    end
    check("cancel.ok_count", n_ok, 1);
    check("cancel.ok_cycle", first, 46);
    check("cancel.hold_until_ok", hold_bad, 1'b0);
    check("cancel.new_result", result, 64'h00000002_0000000E);
    last_res = 64'h00000002_0000000E;

    // Cancel while in DONE: no result_ok, result untouched.
    prev = last_res;
    launch(EXE_DIVU_OP, 32'd20, 32'd3);
    cyc = 1;
    while (cyc < 33) begin tick(); cyc++; end
    check("cdone.busy_c33", busy, 1'b1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cdone.no_ok", result_ok, 1'b0);
    check("cdone.busy", busy, 1'b0);
    check("cdone.result_kept", result, prev);

    // Cancel together with start in IDLE: nothing launches.
    start = 1'b1; cancel = 1'b1; opa = 32'd8; opb = 32'd2; is_signed = 1'b0;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("cstart.busy", busy, 1'b0);
    n_ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_ok) n_ok++;
      tick();
    end
    check("cstart.no_ok", n_ok, 0);

    // Start pulse while busy is ignored.
    launch(EXE_DIVU_OP, 32'd100, 32'd7);
    cyc = 1; n_ok = 0; first = 0;
    while (cyc <= 80) begin
      start = (cyc == 5);
      if (cyc == 5) begin is_signed = 1'b1; opa = 32'd50; opb = 32'd5; end
      if (result_ok) begin
        n_ok++;
        if (first == 0) first = cyc;
      end
      tick(); cyc++;
    end
    start = 1'b0;
    check("busystart.ok_count", n_ok, 1);
    check("busystart.ok_cycle", first, 34);
    check("busystart.result", result, 64'h00000002_0000000E);

    // Start during the result_ok cycle is dropped.
    launch(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2);
    cyc = 1;
    while (!result_ok && cyc < 60) begin tick(); cyc++; end
    check("okstart.ok_seen", result_ok, 1'b1);
    start = 1'b1; is_signed = 1'b0; opa = 32'd20; opb = 32'd4;
    tick();
    start = 1'b0;
    check("okstart.busy", busy, 1'b0);
    tick();
    check("okstart.no_ok", result_ok, 1'b0);
    check("okstart.result", result, 64'hFFFFFFFF_FFFFFFFD);

    // Randomized operands, biased toward boundary values.
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 32'd0;
        1:       a = 32'h8000_0000;
        2:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'd1;
        3:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      do_op(sgn ? EXE_DIV_OP : EXE_DIVU_OP, a, b, ref_div(sgn, a, b), "rnd");
    end

    // Asynchronous reset mid-CALC, between clock edges.
    launch(EXE_DIVU_OP, 32'd100, 32'd7);
    cyc = 1;
    while (cyc < 15) begin tick(); cyc++; end
    #3;
    rst = 1'b0;
    #1;
    check("arst.busy", busy, 1'b0);
    check("arst.result_ok", result_ok, 1'b0);
    check("arst.result", result, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    do_op(EXE_DIVU_OP, 32'd9, 32'd3, 64'h00000000_00000003, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
